// File: rtl/cordiv_quotient_acc.sv
// Converts the CORDIV unary quotient bitstream back to binary: skips a warm-up
// prefix, counts ones over 2^BW valid bits, and offers the count on a valid/ready port.
module cordiv_quotient_acc #(
    parameter int BW     = 8,
    parameter int WARMUP = 2,
    parameter int WUW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_vld,
    output logic          busy,
    output logic [BW:0]   out_cnt,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WUW-1:0] WU_LAST  = WUW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [BW-1:0]  SMP_LAST = {BW{1'b1}};
    localparam state_t         S_FIRST  = (WARMUP == 0) ? S_RUN : S_WARM;

    state_t          state_r;
    logic [BW:0]     acc_r;
    logic [BW-1:0]   smp_r;
    logic [WUW-1:0]  wu_r;
    logic [BW:0]     out_cnt_r;
    logic            restart_s;
    logic [BW:0]     acc_next_s;

    // A new measurement may begin from IDLE, or from DONE only as the result is taken.
    always_comb begin
        restart_s  = 1'b0;
        acc_next_s = acc_r + {{BW{1'b0}}, bit_in};
        case (state_r)
            S_IDLE:  restart_s = start;
            S_DONE:  restart_s = start & out_ready;
            default: restart_s = 1'b0;
        endcase
    end

    // Measurement sequencer, counters and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            acc_r     <= {(BW+1){1'b0}};
            smp_r     <= {BW{1'b0}};
            wu_r      <= {WUW{1'b0}};
            out_cnt_r <= {(BW+1){1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (restart_s) begin
                        wu_r    <= {WUW{1'b0}};
                        acc_r   <= {(BW+1){1'b0}};
                        smp_r   <= {BW{1'b0}};
                        state_r <= S_FIRST;
                    end else if ((state_r == S_DONE) && out_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                S_WARM: begin
                    if (bit_vld) begin
                        wu_r <= wu_r + WUW'(1);
                        if (wu_r == WU_LAST) begin
                            acc_r   <= {(BW+1){1'b0}};
                            smp_r   <= {BW{1'b0}};
                            state_r <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bit_vld) begin
                        acc_r <= acc_next_s;
                        smp_r <= smp_r + BW'(1);
                        // Final sample folds straight into the result so no cycle is lost.
                        if (smp_r == SMP_LAST) begin
                            out_cnt_r <= acc_next_s;
                            state_r   <= S_DONE;
                        end
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_r == S_WARM) || (state_r == S_RUN);
    assign out_valid = (state_r == S_DONE);
    assign out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_cordiv_quotient_acc.sv
// Randomized scoreboard bench for cordiv_quotient_acc (BW=8, WARMUP=2).
module tb_cordiv_quotient_acc;
    localparam int BW     = 8;
    localparam int WARMUP = 2;
    localparam int WIN    = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_vld = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [BW:0]   out_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_last = 0;

    always #5 clk = ~clk;

    cordiv_quotient_acc #(.BW(BW), .WARMUP(WARMUP), .WUW(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_vld(bit_vld),
        .busy(busy), .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream pattern by index among valid bits since start (index 0 = first warm-up bit).
    function automatic logic gen_bit(input int mode, input int idx);
        int w;
        w = idx - WARMUP;
        case (mode)
            0: return 1'b1;
            1: return idx < 2;
            2: return (w < 0) ? ($urandom_range(1) != 0) : (w % 2 == 0);
            3: return 1'b0;
            4: return (w >= 0) && (w < 200) && (w % 2 == 0);
            default: return $urandom_range(1) != 0;
        endcase
    endfunction

    // Monitor: pops the expected count on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (out_valid && exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: out_cnt=%0d with no expected result", out_cnt);
            end else if (out_valid && out_ready) begin
                check("out_cnt", int'(out_cnt), exp_q.pop_front());
            end
        end
    end

    // rdy_mode: 0 hold low, 1 high, 2 random while the window runs.
    task automatic run_meas(input int mode, input int drop_pct, input int rdy_mode,
                            input bit noise_start, input int exp_lat);
        int  nvalid;
        int  ones;
        int  lat;
        bit  done_win;
        logic v;
        logic b;
        nvalid = 0; ones = 0; lat = 0; done_win = 1'b0;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
        for (int k = 1; k <= 2000 && lat == 0; k++) begin
            @(negedge clk);
            start = noise_start && !done_win && ($urandom_range(3) == 0);
            out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : ($urandom_range(1) != 0);
            v = done_win ? ($urandom_range(1) != 0) : ($urandom_range(99) >= drop_pct);
            b = done_win ? ($urandom_range(1) != 0) : gen_bit(mode, nvalid);
            bit_vld = v;
            bit_in = b;
            if (v && !done_win) begin
                if (nvalid >= WARMUP) ones += int'(b);
                nvalid++;
                if (nvalid == WARMUP + WIN) begin
                    done_win = 1'b1;
                    exp_q.push_back(ones);
                    exp_last = ones;
                end
            end
            #4;
            if (k == 1) begin
                check("busy_after_start", int'(busy), 1);
                check("valid_after_start", int'(out_valid), 0);
            end
            if (out_valid) lat = k;
        end
        start = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid never rose for mode %0d", mode);
        end else if (exp_lat > 0) begin
            check("latency", lat, exp_lat);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #4;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_cnt", int'(out_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_meas(0, 0, 1, 1'b0, WARMUP + WIN + 1);
        run_meas(1, 0, 1, 1'b0, WARMUP + WIN + 1);
        run_meas(2, 30, 1, 1'b0, 0);

        run_meas(5, 20, 0, 1'b0, 0);
        repeat (20) begin
            @(negedge clk);
            start = ($urandom_range(1) != 0);
            out_ready = 1'b0;
            bit_vld = ($urandom_range(1) != 0);
            bit_in = ($urandom_range(1) != 0);
            #4;
            check("hold_valid", int'(out_valid), 1);
            check("hold_cnt", int'(out_cnt), exp_last);
        end
        run_meas(3, 0, 1, 1'b0, WARMUP + WIN + 1);
        run_meas(4, 0, 1, 1'b1, WARMUP + WIN + 1);
        for (int r = 0; r < 3; r++) run_meas(5, 25, 2, 1'b0, 0);

        // Abort a measurement with reset partway through the window.
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_valid", int'(out_valid), 0);
        check("async_cnt", int'(out_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("idle_after_reset", int'(busy), 0);
        run_meas(0, 0, 1, 1'b0, WARMUP + WIN + 1);

        @(negedge clk);
        start = 1'b0; out_ready = 1'b1; bit_vld = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("queue_drained", exp_q.size(), 0);
        check("final_idle_valid", int'(out_valid), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordiv_quotient_acc.md
Name: cordiv_quotient_acc

Overview:
- Downstream consumer of the CORDIV divider kernel's unary quotient bitstream; converts it back to binary.
- Per measurement: discards a warm-up prefix (divider shift-register fill), then counts ones over exactly 2^BW valid stream cycles.
- Presents the count on a valid/ready output port; feeds the binary result back to the host/scoreboard side of the unary datapath.

Parameters:
- BW, 8, log2 of measurement window length; result is a count of ones over 2^BW valid bits.
- WARMUP, 2, number of valid input bits discarded after start before counting (0 allowed); set to kernel DEP.
- WUW, 2, width of warm-up counter; must satisfy 2^WUW > WARMUP.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a measurement; sampled only in IDLE, or in DONE together with out_ready
- bit_in  input  1  quotient bitstream from divider
- bit_vld  input  1  bit_in is valid this cycle; cycles with bit_vld=0 are neither counted nor discarded
- busy  output  1  high in WARM or RUN
- out_cnt  output  BW+1  number of ones in window, 0..2^BW
- out_valid  output  1  out_cnt holds a completed result
- out_ready  input  1  consumer accepts out_cnt

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, out_valid=0, out_cnt=0, acc=0, sample counter=0, warm-up counter=0. Reset mid-measurement aborts it; no partial result is ever presented.
- States: IDLE, WARM, RUN, DONE; all registered; busy and out_valid decoded from state.
- IDLE:
  - start=1 -> WARM with warm-up counter cleared; if WARMUP=0, go directly to RUN.
  - On entry to RUN: acc and sample counter cleared.
- WARM:
  - Each cycle with bit_vld=1 increments the warm-up counter; bit_in is ignored.
  - The cycle the WARMUP-th valid bit is consumed -> RUN next cycle.
- RUN:
  - Each bit_vld=1 cycle: acc += bit_in; sample counter (BW bits) += 1.
  - The cycle sample counter = 2^BW-1 with bit_vld=1 is the final sample; out_cnt <= acc + bit_in registered; state -> DONE.
  - out_valid rises the cycle after the final bit is sampled.
  - acc is BW+1 bits and never saturates; all-ones gives exactly 2^BW.
- DONE:
  - out_valid=1; out_cnt held stable until handshake (out_valid & out_ready).
  - Handshake without start -> IDLE.
  - Handshake with start=1 same cycle -> WARM (or RUN if WARMUP=0); back-to-back measurements lose no cycles.
  - start without out_ready is ignored.
- start while busy: ignored, no restart.
- bit_vld=0 cycles: hold all counters; no timeout.
- out_cnt retains the last result after the handshake until the next result is loaded.
- Latency: start accepted at cycle t -> out_valid no earlier than t + WARMUP + 2^BW + 1 with continuous bit_vld.

Test Plan:
- BW=8, WARMUP=2, bit_vld=1 constant, bit_in=1 always; pulse start -> out_valid rises exactly 2+256+1 cycles after start accepted; out_cnt=256.
- bit_in=1 for first 2 valid bits then 0 forever -> out_cnt=0; confirms warm-up discard. Repeat with WARMUP=0 -> out_cnt=2.
- bit_in alternating 1,0 after warm-up, bit_vld randomly low ~30% of cycles -> out_cnt=128; zero-vld cycles do not advance either counter.
- Result ready with out_ready=0 for 20 cycles -> out_valid and out_cnt stable throughout.
  - out_ready=1 with start=1 -> next cycle busy=1, out_valid=0.
  - Second window of all zeros -> out_cnt=0.
- start pulsed repeatedly mid-RUN -> ignored; result for 100 ones in window = 100.
- rst_n low for 1 cycle mid-RUN -> all outputs 0 immediately (async); IDLE afterwards; fresh start gives correct full-window count.
